lemming_tracker: RTL
====================

Name: lemming_tracker

Overview:
- Downstream consumer of the lemming behaviour FSM outputs (walk_left, walk_right, aah, digging, jumping).
- Integrates those one-hot activity flags into world state: horizontal position, dig depth and fall duration.
- Detects fatal falls and produces registered wall-contact flags that the integration layer routes back as bump_left/bump_right.
- Pure bookkeeping: no terrain memory, one movement step per tick.

Parameters:
X_WIDTH, 8, width of horizontal position.
X_START, 64, position loaded at reset.
X_MIN, 0, left wall coordinate (inclusive).
X_MAX, 255, right wall coordinate (inclusive); must satisfy X_MIN < X_MAX ≤ 2^X_WIDTH-1.
FALL_LIMIT, 20, largest survivable fall in ticks.
DIG_TICKS, 4, digging ticks per depth unit (≥1).

Ports:
clk  in  1  system clock, rising edge.
areset_n  in  1  asynchronous active-low reset.
tick  in  1  movement enable; all state updates occur only on cycles with tick=1.
walk_left  in  1  FSM output: walking left.
walk_right  in  1  FSM output: walking right.
aah  in  1  FSM output: falling.
digging  in  1  FSM output: digging.
jumping  in  1  FSM output: jumping.
x_pos  out  X_WIDTH  current horizontal position.
depth  out  4  dig depth, saturates at 15.
fall_cnt  out  5  ticks spent in the current fall, saturates at 31.
at_left_wall  out  1  level: x_pos==X_MIN.
at_right_wall  out  1  level: x_pos==X_MAX.
splat  out  1  one-cycle pulse on fatal landing.
alive  out  1  1 until a fatal landing.
illegal  out  1  one-cycle pulse: >1 activity flag high on a tick.
step_count  out  16  count of ticks with a successful x move, wraps.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (areset_n). All outputs are registered.
- Reset values: x_pos=X_START, depth=0, fall_cnt=0, dig_cnt=0, dir=LEFT, state=ALIVE, alive=1, splat=0, illegal=0, step_count=0. Wall flags are derived from the reset x_pos.
- Latency: an input sampled on a tick edge is reflected on the outputs after that edge (1 cycle). With tick=0, all state holds and the splat/illegal pulses clear.
- Internal dir register: set to LEFT on walk_left, RIGHT on walk_right; otherwise holds.
- State machine:
  - ALIVE: normal tracking.
  - FALLING: entered from ALIVE on a tick with aah=1.
  - DEAD: terminal; left only via reset.
- Per tick in ALIVE/FALLING, with exactly one activity flag high:
  - walk_left: if x_pos>X_MIN then x_pos-1 and step_count+1; else hold.
  - walk_right: if x_pos<X_MAX then x_pos+1 and step_count+1; else hold.
  - jumping: move 2 in dir, clamped to [X_MIN,X_MAX]. step_count+1 only if x_pos changed. A partial clamp (1 unit) counts as a move.
  - digging: dig_cnt+1. When dig_cnt reaches DIG_TICKS-1: dig_cnt=0 and depth+1 (saturating at 15). Any non-digging tick clears dig_cnt.
  - aah: state=FALLING, fall_cnt+1 (saturating at 31). No x movement.
- Landing: a tick in FALLING with aah=0.
  - If fall_cnt>FALL_LIMIT: state=DEAD, alive=0, splat=1 for one cycle.
  - Otherwise: fall_cnt=0, state=ALIVE, and the non-aah flag on that tick is processed normally.
- Saturated fall_cnt (31) still counts as fatal.
- No flags high on a tick: hold all state. If in FALLING, this is a landing.
- More than one flag high on a tick:
  - illegal=1 for one cycle; x_pos, depth, dig_cnt and step_count hold.
  - If aah is among the flags in FALLING, fall_cnt still increments (fall continues).
- DEAD: every counter and x_pos is frozen, inputs are ignored, and illegal is never raised.
- Reset mid-fall or mid-dig: immediate return to reset values, no splat pulse.
- Wall flags are combinational compares on registered x_pos; no glitch paths from inputs.

Test Plan:
- Reset release, tick every cycle, walk_left 10 ticks → x_pos 64→54, step_count=10, alive=1, at_left_wall=0.
- Start with x_pos forced to 2 via walk_left, then walk_left 5 more ticks → x_pos=0, at_left_wall=1, step_count stops incrementing; then walk_right 1 tick, jumping 1 tick → x_pos=3 (dir=RIGHT), step_count+2.
- digging 9 ticks with DIG_TICKS=4 → depth=2, dig_cnt=1; then walk_right 1 tick, digging 3 ticks → depth still 2 (dig_cnt restarted).
- aah 20 ticks then aah=0 with walk_left → fall_cnt returns to 0, alive=1, x_pos decrements on landing tick; aah 21 ticks then aah=0 → splat pulse exactly 1 cycle, alive=0, further walk_right ticks leave x_pos unchanged.
- walk_left and jumping high together on a tick → illegal=1 for one cycle, x_pos/step_count unchanged; tick=0 cycles with flags toggling → no state change.
- areset_n asserted asynchronously mid-fall at fall_cnt=15 → outputs return to reset values before the next clk edge, splat never pulses.

Source files
------------

// File: rtl/lemming_if.sv
// Bundles the behaviour-FSM activity flags and the tracker's world-state outputs.
interface lemming_if #(
  parameter int X_WIDTH = 8
);
  logic               tick;
  logic               walk_left;
  logic               walk_right;
  logic               aah;
  logic               digging;
  logic               jumping;
  logic [X_WIDTH-1:0] x_pos;
  logic [3:0]         depth;
  logic [4:0]         fall_cnt;
  logic               at_left_wall;
  logic               at_right_wall;
  logic               splat;
  logic               alive;
  logic               illegal;
  logic [15:0]        step_count;

  // Master drives the activity flags and observes the world state.
  modport master (
    output tick, walk_left, walk_right, aah, digging, jumping,
    input  x_pos, depth, fall_cnt, at_left_wall, at_right_wall,
           splat, alive, illegal, step_count
  );

  // Slave is the tracker itself.
  modport slave (
    input  tick, walk_left, walk_right, aah, digging, jumping,
    output x_pos, depth, fall_cnt, at_left_wall, at_right_wall,
           splat, alive, illegal, step_count
  );
endinterface

// File: rtl/lemming_tracker.sv
// Integrates the lemming behaviour FSM flags into position, dig depth and
// fall duration; detects fatal landings and flags wall contact.
module lemming_tracker #(
  parameter int X_WIDTH    = 8,
  parameter int X_START    = 64,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 255,
  parameter int FALL_LIMIT = 20,
  parameter int DIG_TICKS  = 4
) (
  input  logic     clk,
  input  logic     areset_n,
  lemming_if.slave bus
);

  localparam int DIG_W = (DIG_TICKS > 1) ? $clog2(DIG_TICKS) : 1;

  localparam logic [X_WIDTH-1:0] X_START_C  = X_WIDTH'(X_START);
  localparam logic [X_WIDTH-1:0] X_MIN_C    = X_WIDTH'(X_MIN);
  localparam logic [X_WIDTH-1:0] X_MAX_C    = X_WIDTH'(X_MAX);
  localparam logic [X_WIDTH:0]   X_MIN_W    = (X_WIDTH+1)'(X_MIN);
  localparam logic [X_WIDTH:0]   X_MAX_W    = (X_WIDTH+1)'(X_MAX);
  localparam logic [X_WIDTH:0]   TWO_W      = (X_WIDTH+1)'(2);
  localparam logic [4:0]         FALL_LIM_C = 5'(FALL_LIMIT);
  localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(DIG_TICKS - 1);

  typedef enum logic [1:0] {ALIVE, FALLING, DEAD} state_t;
  typedef enum logic {LEFT, RIGHT} dir_t;

  state_t             state_reg, state_next;
  dir_t               dir_reg, dir_next;
  logic [X_WIDTH-1:0] x_reg, x_next;
  logic [3:0]         depth_reg, depth_next;
  logic [4:0]         fall_reg, fall_next;
  logic [DIG_W-1:0]   dig_reg, dig_next;
  logic [15:0]        step_reg, step_next;
  logic               splat_reg, splat_next;
  logic               illegal_reg, illegal_next;

  logic [4:0]         flags;
  logic               multi;
  logic [4:0]         fall_inc;
  logic [X_WIDTH:0]   x_wide;
  logic [X_WIDTH:0]   jump_wide;
  logic [X_WIDTH-1:0] jump_x;

  assign flags    = {bus.walk_left, bus.walk_right, bus.aah, bus.digging, bus.jumping};
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi    = |(flags & (flags - 5'd1));
  assign fall_inc = (fall_reg == 5'd31) ? fall_reg : fall_reg + 5'd1;

  // Jump target: two units in the current direction, clamped at the walls.
  // Done one bit wider so the +/-2 cannot wrap before the clamp compare.
  assign x_wide    = {1'b0, x_reg};
  assign jump_wide = (dir_reg == LEFT)
                   ? ((x_wide >= X_MIN_W + TWO_W) ? x_wide - TWO_W : X_MIN_W)
                   : ((x_wide + TWO_W <= X_MAX_W) ? x_wide + TWO_W : X_MAX_W);
  assign jump_x    = jump_wide[X_WIDTH-1:0];

  // State register bank; reset abandons any fall or dig in progress.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg   <= ALIVE;
      dir_reg     <= LEFT;
      x_reg       <= X_START_C;
      depth_reg   <= 4'd0;
      fall_reg    <= 5'd0;
      dig_reg     <= '0;
      step_reg    <= 16'd0;
      splat_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      x_reg       <= x_next;
      depth_reg   <= depth_next;
      fall_reg    <= fall_next;
      dig_reg     <= dig_next;
      step_reg    <= step_next;
      splat_reg   <= splat_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state: hold by default, act only on ticks while not dead.
  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    x_next       = x_reg;
    depth_next   = depth_reg;
    fall_next    = fall_reg;
    dig_next     = dig_reg;
    step_next    = step_reg;
    splat_next   = 1'b0;
    illegal_next = 1'b0;
    if (bus.tick && (state_reg != DEAD)) begin
      if (multi) begin
        // Conflicting flags: freeze everything except an ongoing fall,
        // which keeps accumulating while aah is asserted. Not a landing.
        illegal_next = 1'b1;
        if ((state_reg == FALLING) && bus.aah) begin
          fall_next = fall_inc;
        end
      end else if ((state_reg == FALLING) && !bus.aah && (fall_reg > FALL_LIM_C)) begin
        state_next = DEAD;
        splat_next = 1'b1;
      end else begin
        // Survivable landing resets the fall, then the flag is handled as usual.
        if ((state_reg == FALLING) && !bus.aah) begin
          fall_next  = 5'd0;
          state_next = ALIVE;
        end
        if (bus.walk_left) begin
          dir_next = LEFT;
          dig_next = '0;
          if (x_reg > X_MIN_C) begin
            x_next    = x_reg - 1'b1;
            step_next = step_reg + 16'd1;
          end
        end else if (bus.walk_right) begin
          dir_next = RIGHT;
          dig_next = '0;
          if (x_reg < X_MAX_C) begin
            x_next    = x_reg + 1'b1;
            step_next = step_reg + 16'd1;
          end
        end else if (bus.jumping) begin
          dig_next = '0;
          x_next   = jump_x;
          if (jump_x != x_reg) begin
            step_next = step_reg + 16'd1;
          end
        end else if (bus.digging) begin
          if (dig_reg == DIG_LAST) begin
            dig_next   = '0;
            depth_next = (depth_reg == 4'd15) ? depth_reg : depth_reg + 4'd1;
          end else begin
            dig_next = dig_reg + 1'b1;
          end
        end else if (bus.aah) begin
          dig_next   = '0;
          state_next = FALLING;
          fall_next  = fall_inc;
        end
      end
    end
  end

  assign bus.x_pos         = x_reg;
  assign bus.depth         = depth_reg;
  assign bus.fall_cnt      = fall_reg;
  assign bus.step_count    = step_reg;
  assign bus.splat         = splat_reg;
  assign bus.illegal       = illegal_reg;
  assign bus.alive         = (state_reg != DEAD);
  assign bus.at_left_wall  = (x_reg == X_MIN_C);
  assign bus.at_right_wall = (x_reg == X_MAX_C);

endmodule
